// File: rtl/weight_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : weight_fifo_reader
// Brief    : Pops one zero-padded weight tile from the weight FIFO and
//            scatters it into the Tn-banked weight buffer.
// Revision : 1.0 - initial release
// ============================================================================
module weight_fifo_reader #(
    parameter int AW = 16,
    parameter int CW = 16,
    parameter int DW = 32,
    parameter int K  = 3,
    parameter int Tm = 16,
    parameter int Tn = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          fifo_empty,
    output logic          fifo_pop,
    input  logic [DW-1:0] data_from_fifo,
    output logic [Tn-1:0] wbuf_wena,
    output logic [AW-1:0] wbuf_waddr,
    output logic [DW-1:0] wbuf_wdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_one    = CW'(1);
    localparam logic [CW-1:0] c_k      = CW'(K);
    localparam logic [CW-1:0] c_kk     = CW'(K * K);
    localparam logic [CW-1:0] c_k_max  = CW'(K - 1);
    localparam logic [CW-1:0] c_tm_max = CW'(Tm - 1);
    localparam logic [CW-1:0] c_tn_max = CW'(Tn - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] kc_q, kc_d;
    logic [CW-1:0] kr_q, kr_d;
    logic [CW-1:0] tm_q, tm_d;
    logic [CW-1:0] tn_q, tn_d;

    // One-stage write pipeline: FIFO data arrives the cycle after the pop.
    logic          pop_dly_q;
    logic [CW-1:0] tn_dly_q;
    logic [AW-1:0] addr_dly_q;

    logic [CW-1:0] w_addr;
    logic          w_last;

    assign w_addr = tm_q * c_kk + kr_q * c_k + kc_q;
    assign w_last = (kc_q == c_k_max) && (kr_q == c_k_max) &&
                    (tm_q == c_tm_max) && (tn_q == c_tn_max);

    always_comb begin
        state_d  = state_q;
        kc_d     = kc_q;
        kr_d     = kr_q;
        tm_d     = tm_q;
        tn_d     = tn_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                fifo_pop = !fifo_empty;
                if (fifo_pop) begin
                    // Nested odometer kc -> kr -> tm -> tn; the last pop wraps to zero.
                    if (kc_q == c_k_max) begin
                        kc_d = '0;
                        if (kr_q == c_k_max) begin
                            kr_d = '0;
                            if (tm_q == c_tm_max) begin
                                tm_d = '0;
                                tn_d = (tn_q == c_tn_max) ? '0 : tn_q + c_one;
                            end else begin
                                tm_d = tm_q + c_one;
                            end
                        end else begin
                            kr_d = kr_q + c_one;
                        end
                    end else begin
                        kc_d = kc_q + c_one;
                    end
                    if (w_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            kc_q       <= '0;
            kr_q       <= '0;
            tm_q       <= '0;
            tn_q       <= '0;
            pop_dly_q  <= 1'b0;
            tn_dly_q   <= '0;
            addr_dly_q <= '0;
        end else begin
            state_q    <= state_d;
            kc_q       <= kc_d;
            kr_q       <= kr_d;
            tm_q       <= tm_d;
            tn_q       <= tn_d;
            pop_dly_q  <= fifo_pop;
            tn_dly_q   <= tn_q;
            addr_dly_q <= w_addr[AW-1:0];
        end
    end

    for (genvar gi = 0; gi < Tn; gi++) begin : g_bank
        assign wbuf_wena[gi] = pop_dly_q && (tn_dly_q == CW'(gi));
    end

    assign wbuf_waddr = addr_dly_q;
    assign wbuf_wdata = data_from_fifo;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_weight_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_fifo_reader
// Brief    : Directed bench for weight_fifo_reader, small (K3/Tm2/Tn2) and
//            default-size instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fifo_reader;

    localparam int SK   = 3;
    localparam int STM  = 2;
    localparam int STN  = 2;
    localparam int SW   = STM * SK * SK;   // words per bank (18)
    localparam int STOT = STN * SW;        // words per tile (36)

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_start = 1'b0, s_empty = 1'b0, s_pop, s_busy, s_done, s_clr = 1'b0;
    logic [31:0] s_data = '0, s_wdata, s_base = 32'h1000_0000, s_cnt = '0;
    logic [1:0]  s_wena;
    logic [15:0] s_waddr;

    logic        b_start = 1'b0, b_empty = 1'b0, b_pop, b_busy, b_done;
    logic [31:0] b_data = '0, b_wdata, b_cnt = '0;
    logic [15:0] b_wena;
    logic [15:0] b_waddr;

    weight_fifo_reader #(.AW(16), .CW(16), .DW(32), .K(SK), .Tm(STM), .Tn(STN)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .fifo_empty(s_empty), .fifo_pop(s_pop),
        .data_from_fifo(s_data), .wbuf_wena(s_wena), .wbuf_waddr(s_waddr),
        .wbuf_wdata(s_wdata), .busy(s_busy), .done(s_done)
    );

    weight_fifo_reader u_big (
        .clk(clk), .rst(rst), .start(b_start), .fifo_empty(b_empty), .fifo_pop(b_pop),
        .data_from_fifo(b_data), .wbuf_wena(b_wena), .wbuf_waddr(b_waddr),
        .wbuf_wdata(b_wdata), .busy(b_busy), .done(b_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // FIFO models: popped word appears on the data bus the following cycle.
    always @(posedge clk) begin
        if (s_clr) begin
            s_cnt <= '0;
        end else if (s_pop) begin
            s_data <= s_base + s_cnt;
            s_cnt  <= s_cnt + 32'd1;
        end
        if (b_pop) begin
            b_data <= b_cnt;
            b_cnt  <= b_cnt + 32'd1;
        end
    end

    int cyc = 0;
    int s_pops = 0, s_wr = 0, s_wr_next = 0, s_dones = 0, s_last_pop = 0;
    bit s_prev_done = 1'b0;
    int s_bank_log [STOT];
    int s_addr_log [STOT];
    int idx, bank;

    int b_wr = 0, b_dones = 0, b_first_bank = -1, b_first_addr = -1;
    int b_last_bank = -1, b_last_addr = -1, b_last_data = -1, bbank;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (s_empty) check("pop_while_empty", s_pop, 0);
            if (s_pop) begin
                s_pops++;
                s_last_pop = cyc;
            end
            if (s_wena != 2'b00) begin
                idx  = int'(s_wdata - s_base);
                bank = -1;
                for (int b = 0; b < STN; b++) if (s_wena[b]) bank = b;
                check("wena_onehot", $countones(s_wena), 1);
                check("write_order", idx, s_wr_next);
                check("bank_map", bank, idx / SW);
                check("addr_map", s_waddr, idx % SW);
                if (idx >= 0 && idx < STOT) begin
                    s_bank_log[idx] = bank;
                    s_addr_log[idx] = int'(s_waddr);
                end
                s_wr++;
                s_wr_next++;
            end
            if (s_done) begin
                s_dones++;
                check("done_latency", cyc - s_last_pop, 2);
            end
            if (s_prev_done) check("busy_after_done", s_busy, 0);
            s_prev_done = s_done;

            if (b_wena != 16'h0000) begin
                bbank = -1;
                for (int b = 0; b < 16; b++) if (b_wena[b]) bbank = b;
                if (b_wr == 0) begin
                    b_first_bank = bbank;
                    b_first_addr = int'(b_waddr);
                end
                b_last_bank = bbank;
                b_last_addr = int'(b_waddr);
                b_last_data = int'(b_wdata);
                b_wr++;
            end
            if (b_done) b_dones++;
        end
    end

    task automatic check_word(input string tag, input int w, input int exp_bank, input int exp_addr);
        check({tag, "_bank"}, s_bank_log[w], exp_bank);
        check({tag, "_addr"}, s_addr_log[w], exp_addr);
    endtask

    // Runs one small tile; exits in the IDLE cycle after done (or after an abort reset).
    task automatic run_tile(input bit toggle, input bit restart, input int abort_at, input bit b2b);
        int  start_dones;
        int  budget;
        bit  restarted;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < STOT; i++) begin
            s_bank_log[i] = -1;
            s_addr_log[i] = -1;
        end
        s_base      = s_base + 32'h0100_0000;
        s_wr_next   = 0;
        s_wr        = 0;
        s_pops      = 0;
        start_dones = s_dones;
        restarted   = 1'b0;
        s_start     = 1'b1;
        s_clr       = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_clr   = 1'b0;
        for (budget = 0; budget < 400 && s_dones == start_dones; budget++) begin
            s_empty = toggle ? ((budget % 2) == 1) : 1'b0;
            s_start = 1'b0;
            if (restart && !restarted && s_pops == 10) begin
                s_start   = 1'b1;
                restarted = 1'b1;
            end
            if (abort_at > 0 && s_pops >= abort_at) begin
                rst = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        s_start = 1'b0;
        s_empty = 1'b0;
        if (abort_at > 0) begin
            @(posedge clk); #1;
            rst = 1'b0;
            check("abort_busy", s_busy, 0);
            check("abort_wena", s_wena, 0);
            check("abort_no_done", s_dones - start_dones, 0);
        end else begin
            check("tile_timeout", (budget < 400), 1);
            check("writes_per_tile", s_wr, STOT);
            check("pops_per_tile", s_pops, STOT);
            check("dones_per_tile", s_dones - start_dones, 1);
        end
    endtask

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", s_busy, 0);
        check("rst_done", s_done, 0);
        check("rst_pop", s_pop, 0);
        check("rst_wena", s_wena, 0);
        check("rst_waddr", s_waddr, 0);
        check("rst_big_busy", b_busy, 0);
        check("rst_big_wena", b_wena, 0);
        rst = 1'b0;

        run_tile(1'b0, 1'b0, 0, 1'b0);
        check_word("w0", 0, 0, 0);
        check_word("w9", 9, 0, 9);
        check_word("w17", 17, 0, 17);
        check_word("w18", 18, 1, 0);
        check_word("w35", 35, 1, 17);

        run_tile(1'b1, 1'b0, 0, 1'b0);
        check_word("stall_w18", 18, 1, 0);
        check_word("stall_w35", 35, 1, 17);

        run_tile(1'b0, 1'b1, 0, 1'b0);
        check_word("restart_w10", 10, 0, 10);
        check_word("restart_w35", 35, 1, 17);
        repeat (4) @(posedge clk);
        #1;
        check("restart_single_done_busy", s_busy, 0);

        run_tile(1'b0, 1'b0, 20, 1'b0);
        run_tile(1'b0, 1'b0, 0, 1'b0);
        check_word("post_rst_w0", 0, 0, 0);
        check_word("post_rst_w35", 35, 1, 17);

        run_tile(1'b0, 1'b0, 0, 1'b1);
        check_word("b2b_w0", 0, 0, 0);
        check_word("b2b_w27", 27, 1, 9);

        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (budget = 0; budget < 3000 && b_dones == 0; budget++) begin
            @(posedge clk); #1;
        end
        check("big_timeout", (budget < 3000), 1);
        repeat (5) @(posedge clk);
        #1;
        check("big_writes", b_wr, 2304);
        check("big_first_bank", b_first_bank, 0);
        check("big_first_addr", b_first_addr, 0);
        check("big_last_bank", b_last_bank, 15);
        check("big_last_addr", b_last_addr, 143);
        check("big_last_data", b_last_data, 2303);
        check("big_dones", b_dones, 1);
        check("big_busy_end", b_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_fifo_reader.md
Name: weight_fifo_reader

Overview:
Drains one weight tile from the weight FIFO after the fill side has zero-padded it. Each popped word is scattered into the Tn-banked on-chip weight buffer. Word order is fixed: kc fastest, then kr, then tm, then tn. The block sits between the weight FIFO read port and the weight buffer write ports, and signals tile completion to the layer controller.

Parameters:
AW, 16, weight buffer address width; must satisfy 2^AW >= Tm*K*K
CW, 16, counter width
DW, 32, data word width
K, 3, kernel size (kr and kc range 0..K-1)
Tm, 16, output-channel tile depth (tm range 0..Tm-1)
Tn, 16, input-channel tile depth = number of buffer banks (tn range 0..Tn-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a tile load; honoured only in IDLE
fifo_empty  in  1  weight FIFO empty flag
fifo_pop  out  1  FIFO read strobe; data returns on data_from_fifo one cycle later
data_from_fifo  in  DW  FIFO read data, valid the cycle after fifo_pop
wbuf_wena  out  Tn  one-hot bank write enable; bit tn selects the bank
wbuf_waddr  out  AW  address within the bank = tm*K*K + kr*K + kc
wbuf_wdata  out  DW  write data, equal to data_from_fifo
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of the tile

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state goes to IDLE; all counters cleared to 0.
  - fifo_pop=0, wbuf_wena=0, wbuf_waddr=0, busy=0, done=0.
  - Applies mid-tile too: an in-flight write is dropped, and the next cycle starts clean.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: start=1 -> LOAD.
  - LOAD: fifo_pop = !fifo_empty (combinational from the state). Each pop advances the nested counter kc -> kr -> tm -> tn, wrapping each at its max. A pop issued while the counter is at the last position (kc=K-1, kr=K-1, tm=Tm-1, tn=Tn-1) -> DRAIN, and the counter wraps to all zero.
  - DRAIN: fifo_pop=0; the last write completes this cycle; -> DONE.
  - DONE: done=1 for exactly one cycle; -> IDLE.
- Write pipeline:
  - The counter values and the pop strobe are registered one stage as pop_d, tn_d and addr_d.
  - In the cycle after a pop: wbuf_wena = pop_d ? (1<<tn_d) : 0; wbuf_waddr = addr_d; wbuf_wdata = data_from_fifo.
  - When no write is in progress, wbuf_wena=0; wbuf_waddr and wbuf_wdata are don't-care.
- Latency: the first write occurs 1 cycle after the first pop. done is asserted 2 cycles after the final pop: the DRAIN write, then the DONE pulse.
- Total pops per tile = Tn*Tm*K*K; no more, no fewer.
- Boundary conditions:
  - FIFO empty in LOAD: no pop, counters hold, wena=0 next cycle; stalls may occur anywhere in the tile.
  - start while busy: ignored; no counter effect.
  - start and rst in the same cycle: rst wins.
  - Address arithmetic is done at CW width, then truncated to AW; no overflow for legal parameters.

Test Plan:
- K=3, Tm=2, Tn=2, FIFO always non-empty, data = 0..35, start pulse -> 36 consecutive pops.
  - Word 0 -> bank0 addr0; word 9 -> bank0 addr9; word 17 -> bank0 addr17; word 18 -> bank1 addr0; word 35 -> bank1 addr17.
  - done pulses exactly 2 cycles after the 36th pop; busy falls the cycle after done.
- Same configuration, fifo_empty toggled every other cycle -> fifo_pop never asserts while empty; identical bank/address/data mapping; total of 36 writes.
- start pulsed again at pop 10 -> ignored; mapping unchanged; exactly one done.
- rst asserted after pop 20, then a fresh start -> busy=0, wena=0 the cycle after reset; the new tile starts at bank0 addr0 and runs all 36 writes.
- Back-to-back tiles: start issued the cycle after done -> second tile maps identically to the first; no write of stale pipeline data between tiles.
- Default parameters (K=3, Tm=16, Tn=16), 2304 words -> final write bank15 addr143; done asserted once.
